// File: rtl/branch_predictor_pkg.sv
// Shared definitions for the branch target buffer / predictor.
//   BTB_ENTRIES : number of direct-mapped table entries
//   IDX_W       : index width, taken from PC[5:2]
//   TAG_W       : tag width, taken from PC[31:6]
//   ctr_t       : 2-bit saturating counter encodings (MSB = predict taken)
package branch_predictor_pkg;

  localparam int BTB_ENTRIES = 16;
  localparam int IDX_W       = 4;
  localparam int TAG_W       = 26;

  typedef enum logic [1:0] {
    SNT = 2'b00,  // strongly not taken
    WNT = 2'b01,  // weakly not taken (reset value)
    WT  = 2'b10,  // weakly taken (fresh branch allocation)
    ST  = 2'b11   // strongly taken (jumps)
  } ctr_t;

endpackage

// File: rtl/branch_predictor_sat_counter2.sv
// Next-state logic for a 2-bit saturating taken/not-taken counter.
// Ports:
//   ctr     : current counter value
//   taken   : resolved outcome (1 = taken)
//   nextCtr : counter value after applying the outcome, clamped to SNT..ST
module sat_counter2
  import branch_predictor_pkg::*;
(
  input  logic [1:0] ctr,
  input  logic       taken,
  output logic [1:0] nextCtr
);

  always_comb begin
    nextCtr = ctr;
    if (taken) begin
      if (ctr != ST) nextCtr = ctr + 2'd1;
    end else begin
      if (ctr != SNT) nextCtr = ctr - 2'd1;
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped 16-entry branch target buffer with 2-bit counters.
// Lookup in fetch is purely combinational on PCF; training happens from the
// execute stage on every resolved branch / j / jr. Two saturating statistics
// counters track resolved control transfers and mispredictions.
// Ports:
//   clk, rst_n      : clock, asynchronous active-low reset
//   PCF             : fetch PC for lookup
//   PCE             : execute PC of the resolving instruction
//   BranchE/JumpE/JumpRE : execute instruction is branch / j / jr
//   PCSrcE          : actual redirect taken in execute
//   JumpPredictE    : prediction that was made for the execute instruction
//   TargetE         : resolved taken target
//   JumpPredictF    : predict taken for PCF
//   PredictTargetF  : predicted target (0 when not predicting taken)
//   BranchCount     : saturating count of resolved control transfers
//   MispredictCount : saturating count of mispredictions
module branch_predictor
  import branch_predictor_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] PCF,
  input  logic [31:0] PCE,
  input  logic        BranchE,
  input  logic        JumpE,
  input  logic        JumpRE,
  input  logic        PCSrcE,
  input  logic        JumpPredictE,
  input  logic [31:0] TargetE,
  output logic        JumpPredictF,
  output logic [31:0] PredictTargetF,
  output logic [15:0] BranchCount,
  output logic [15:0] MispredictCount
);

  logic [BTB_ENTRIES-1:0] validQ;
  logic [TAG_W-1:0]       tagQ    [BTB_ENTRIES];
  logic [31:0]            targetQ [BTB_ENTRIES];
  logic [1:0]             ctrQ    [BTB_ENTRIES];

  // Instructions are word aligned, so the byte-offset bits carry no information.
  logic unusedBits;
  assign unusedBits = ^{PCF[1:0], PCE[1:0]};

  // ---------------- fetch-side lookup ----------------
  logic [IDX_W-1:0] idxF;
  logic [TAG_W-1:0] tagF;
  logic             hitF;

  assign idxF = PCF[5:2];
  assign tagF = PCF[31:6];
  assign hitF = validQ[idxF] && (tagQ[idxF] == tagF);

  // Reads the registered table directly: a same-cycle update to this index
  // becomes visible only after the edge.
  assign JumpPredictF   = hitF && ctrQ[idxF][1];
  assign PredictTargetF = JumpPredictF ? targetQ[idxF] : 32'd0;

  // ---------------- execute-side update ----------------
  logic [IDX_W-1:0] idxE;
  logic [TAG_W-1:0] tagE;
  logic             hitE;
  logic             updE;
  logic             isJump;
  logic [1:0]       ctrE;
  logic [1:0]       branchNextCtr;
  logic             wrEntry;
  logic             wrTarget;
  logic [1:0]       newCtr;
  logic             mispredict;

  assign idxE       = PCE[5:2];
  assign tagE       = PCE[31:6];
  assign hitE       = validQ[idxE] && (tagQ[idxE] == tagE);
  assign updE       = BranchE | JumpE | JumpRE;
  assign isJump     = JumpE | JumpRE;
  assign ctrE       = ctrQ[idxE];
  assign mispredict = updE & (PCSrcE ^ JumpPredictE);

  sat_counter2 u_sat (
    .ctr     (ctrE),
    .taken   (PCSrcE),
    .nextCtr (branchNextCtr)
  );

  // Jumps always end up as a strongly-taken entry whether they hit or not;
  // branches train on hit and only allocate when taken.
  always_comb begin
    wrEntry  = 1'b0;
    wrTarget = 1'b0;
    newCtr   = ctrE;
    if (updE) begin
      if (isJump) begin
        wrEntry  = 1'b1;
        wrTarget = 1'b1;
        newCtr   = ST;
      end else if (hitE) begin
        wrEntry  = 1'b1;
        wrTarget = PCSrcE;
        newCtr   = branchNextCtr;
      end else if (PCSrcE) begin
        wrEntry  = 1'b1;
        wrTarget = 1'b1;
        newCtr   = WT;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      validQ <= '0;
      for (int i = 0; i < BTB_ENTRIES; i++) begin
        tagQ[i]    <= '0;
        targetQ[i] <= '0;
        ctrQ[i]    <= WNT;
      end
    end else if (wrEntry) begin
      validQ[idxE] <= 1'b1;
      tagQ[idxE]   <= tagE;
      ctrQ[idxE]   <= newCtr;
      if (wrTarget) targetQ[idxE] <= TargetE;
    end
  end

  // ---------------- statistics ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      BranchCount     <= 16'd0;
      MispredictCount <= 16'd0;
    end else begin
      if (updE && (BranchCount != 16'hFFFF))
        BranchCount <= BranchCount + 16'd1;
      if (mispredict && (MispredictCount != 16'hFFFF))
        MispredictCount <= MispredictCount + 16'd1;
    end
  end

endmodule
